// File: rtl/halo_link.sv
// halo_link: buffered halo-exchange link between a source and a destination PPU.
// Entries {value,row,column} queue in a circular FIFO and drain one per cycle
// to the destination. A small FSM tracks the exchange: IDLE -> STREAM -> DRAIN -> DONE.
//
// Parameters:
//   TILE_SIZE  : tile edge length, coordinate width CW = $clog2(TILE_SIZE)
//   FIFO_DEPTH : buffered entries, power of two >= 2
//
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   src_value/row/column         : entry from the source PPU
//   src_write_enable             : source entry valid this cycle
//   src_exchange_done            : source has issued its last halo entry
//   src_cts                      : clear-to-send back to the source
//   dst_cts                      : destination ready for one entry
//   dst_value/row/column         : registered entry to the destination
//   dst_write_enable             : one-cycle pulse per delivered entry
//   dst_exchange_done            : level, all entries delivered (state DONE)
//   cycle_done                   : global end of PPU cycle, re-arms the link
//   protocol_error               : sticky, a push was rejected
//
// Build option:
//   HALO_LINK_ZERO_DROP_EN : when defined, pushes carrying value 0 are
//                            handshaken but not stored.

module halo_link #(
    parameter int  TILE_SIZE  = 256,
    parameter int  FIFO_DEPTH = 8,
    localparam int CW         = $clog2(TILE_SIZE)
) (
    input  logic          clk,
    input  logic          reset,

    input  logic [7:0]    src_value,
    input  logic [CW-1:0] src_row,
    input  logic [CW-1:0] src_column,
    input  logic          src_write_enable,
    input  logic          src_exchange_done,
    output logic          src_cts,

    input  logic          dst_cts,
    output logic [7:0]    dst_value,
    output logic [CW-1:0] dst_row,
    output logic [CW-1:0] dst_column,
    output logic          dst_write_enable,
    output logic          dst_exchange_done,

    input  logic          cycle_done,
    output logic          protocol_error
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam logic [NW-1:0] DEPTH_N = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [7:0]    value;
        logic [CW-1:0] row;
        logic [CW-1:0] column;
    } entry_t;

    // Storage is not reset; count/pointers alone define validity.
    entry_t        mem_q [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    state_e        state_q, state_d;
    entry_t        out_q, out_d;
    logic          dst_we_q, dst_we_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          accepting;
    logic          push_ok;
    logic          store;
    logic          reject;
    logic          pop;
    logic          mem_we;
    entry_t        push_entry;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign accepting = (state_q == IDLE) || (state_q == STREAM);

    // Full check uses the current count only, so a same-cycle pop does
    // not open room for a push at full.
    assign src_cts = accepting && (count_q < DEPTH_N);
    assign push_ok = src_write_enable && src_cts;
    assign reject  = src_write_enable && !src_cts;
    assign pop     = dst_cts && (count_q != '0);

`ifdef HALO_LINK_ZERO_DROP_EN
    // Zero partial sums carry no information: handshake, don't buffer.
    assign store = push_ok && (src_value != 8'd0);
`else
    assign store = push_ok;
`endif

    assign mem_we = store && !cycle_done;

    assign push_entry.value  = src_value;
    assign push_entry.row    = src_row;
    assign push_entry.column = src_column;

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        dst_we_d = 1'b0;
        err_d    = err_q;

        if (cycle_done) begin
            // Flush: in-flight push/pop this cycle are dropped too.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (store) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                out_d    = mem_q[rd_ptr_q];
                dst_we_d = 1'b1;
            end
            unique case ({store, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (reject) begin
                err_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Exchange FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (cycle_done) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (src_exchange_done) begin
                        state_d = DRAIN;
                    end else if (push_ok) begin
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (src_exchange_done) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    // Wait until the last delivered pulse has retired.
                    if ((count_q == '0) && !dst_we_q) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        done_d = (state_d == DONE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            dst_we_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            dst_we_q <= dst_we_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dst_value         = out_q.value;
    assign dst_row           = out_q.row;
    assign dst_column        = out_q.column;
    assign dst_write_enable  = dst_we_q;
    assign dst_exchange_done = done_q;
    assign protocol_error    = err_q;

endmodule

// File: tb/tb_halo_link.sv
// tb_halo_link: directed and randomized checks of halo_link against a
// queue-based reference model of the link.

module tb_halo_link;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] src_value;
    logic [7:0] src_row;
    logic [7:0] src_column;
    logic       src_write_enable;
    logic       src_exchange_done;
    logic       src_cts;
    logic       dst_cts;
    logic [7:0] dst_value;
    logic [7:0] dst_row;
    logic [7:0] dst_column;
    logic       dst_write_enable;
    logic       dst_exchange_done;
    logic       cycle_done;
    logic       protocol_error;

    halo_link #(
        .TILE_SIZE  (256),
        .FIFO_DEPTH (D)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .src_value         (src_value),
        .src_row           (src_row),
        .src_column        (src_column),
        .src_write_enable  (src_write_enable),
        .src_exchange_done (src_exchange_done),
        .src_cts           (src_cts),
        .dst_cts           (dst_cts),
        .dst_value         (dst_value),
        .dst_row           (dst_row),
        .dst_column        (dst_column),
        .dst_write_enable  (dst_write_enable),
        .dst_exchange_done (dst_exchange_done),
        .cycle_done        (cycle_done),
        .protocol_error    (protocol_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] v;
        logic [7:0] r;
        logic [7:0] c;
    } ent_t;

    // Reference model: a queue of pending entries plus exchange flags.
    ent_t q[$];
    bit   closed;
    bit   done_m;
    bit   err_m;
    bit   we_m;
    ent_t last_m;

    logic [7:0] got[$];

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit keeps(input logic [7:0] v);
`ifdef HALO_LINK_ZERO_DROP_EN
        return v != 8'd0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        closed = 0;
        done_m = 0;
        err_m  = 0;
        we_m   = 0;
        last_m = '0;
    endtask

    task automatic check_outputs();
        chk("dst_write_enable", dst_write_enable, we_m);
        chk("dst_value", dst_value, last_m.v);
        chk("dst_row", dst_row, last_m.r);
        chk("dst_column", dst_column, last_m.c);
        chk("dst_exchange_done", dst_exchange_done, done_m);
        chk("protocol_error", protocol_error, err_m);
    endtask

    // One clock cycle: called #1 after a rising edge, returns #1 after the next.
    task automatic cycle(input bit we, input logic [7:0] v, input logic [7:0] r,
                         input logic [7:0] c, input bit sdone, input bit dcts,
                         input bit cdone);
        bit cts;
        bit nd;
        src_write_enable  = we;
        src_value         = v;
        src_row           = r;
        src_column        = c;
        src_exchange_done = sdone;
        dst_cts           = dcts;
        cycle_done        = cdone;
        #1;
        cts = !closed && (q.size() < D);
        chk("src_cts", src_cts, cts);
        if (cdone) begin
            q.delete();
            closed = 0;
            done_m = 0;
            err_m  = 0;
            we_m   = 0;
        end else begin
            nd = done_m || (closed && q.size() == 0 && !we_m);
            if (we && !cts) err_m = 1;
            if (dcts && q.size() > 0) begin
                last_m = q.pop_front();
                we_m   = 1;
            end else begin
                we_m = 0;
            end
            if (we && cts && keeps(v)) q.push_back('{v, r, c});
            if (sdone) closed = 1;
            done_m = nd;
        end
        @(posedge clk);
        #1;
        check_outputs();
        if (dst_write_enable === 1'b1) got.push_back(dst_value);
    endtask

    task automatic idle(input bit dcts);
        cycle(0, 8'h00, 8'h00, 8'h00, 0, dcts, 0);
    endtask

    task automatic rearm();
        cycle(0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    endtask

    initial begin
        reset             = 1'b1;
        src_value         = '0;
        src_row           = '0;
        src_column        = '0;
        src_write_enable  = 1'b0;
        src_exchange_done = 1'b0;
        dst_cts           = 1'b0;
        cycle_done        = 1'b0;
        model_reset();
        #2;
        check_outputs();
        chk("reset_src_cts", src_cts, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single push, next-cycle delivery, then exchange done.
        cycle(1, 8'h5A, 8'd3, 8'd7, 0, 1, 0);
        cycle(0, 8'h00, 8'h00, 8'h00, 1, 1, 0);
        chk("single_value", dst_value, 8'h5A);
        chk("single_row", dst_row, 8'd3);
        chk("single_col", dst_column, 8'd7);
        idle(1);
        idle(1);
        chk("single_done", dst_exchange_done, 1);
        rearm();

        // Fill to full, overflow push, then drain in order.
        for (int i = 0; i < D; i++)
            cycle(1, 8'(8'h10 + i), 8'(i), 8'(2 * i), 0, 0, 0);
        chk("full_cts_low", src_cts, 0);
        cycle(1, 8'hEE, 8'd1, 8'd1, 0, 0, 0);
        chk("overflow_err", protocol_error, 1);
        got.delete();
        for (int i = 0; i < D + 2; i++) idle(1);
        chk("drain_count", got.size(), D);
        rearm();

        // Full FIFO with simultaneous pop and push: push rejected.
        for (int i = 0; i < D; i++)
            cycle(1, 8'(8'h40 + i), 8'(i), 8'(i), 0, 0, 0);
        cycle(1, 8'h77, 8'd9, 8'd9, 0, 1, 0);
        chk("fullpop_err", protocol_error, 1);
        idle(0);
        chk("count7_cts", src_cts, 1);
        rearm();

        // Three queued, exchange done, dst_cts toggling.
        cycle(1, 8'h21, 8'd1, 8'd2, 0, 0, 0);
        cycle(1, 8'h22, 8'd3, 8'd4, 0, 0, 0);
        cycle(1, 8'h23, 8'd5, 8'd6, 1, 0, 0);
        for (int i = 0; i < 8; i++) idle(i % 2 == 0);
        chk("toggle_done", dst_exchange_done, 1);
        rearm();
        chk("rearm_done", dst_exchange_done, 0);
        chk("rearm_cts", src_cts, 1);
        chk("rearm_err", protocol_error, 0);

        // Reset with five entries queued.
        for (int i = 0; i < 5; i++)
            cycle(1, 8'(8'h60 + i), 8'(i), 8'(i), 0, 0, 0);
        src_write_enable = 1'b0;
        dst_cts          = 1'b1;
        reset            = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("midreset_cts", src_cts, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        got.delete();
        for (int i = 0; i < 6; i++) idle(1);
        chk("post_reset_pulses", got.size(), 0);

        // Zero values.
        got.delete();
        cycle(1, 8'h00, 8'd1, 8'd1, 0, 1, 0);
        cycle(1, 8'h09, 8'd2, 8'd2, 0, 1, 0);
        cycle(1, 8'h00, 8'd3, 8'd3, 0, 1, 0);
        idle(1);
        idle(1);
`ifdef HALO_LINK_ZERO_DROP_EN
        chk("zero_count", got.size(), 1);
`else
        chk("zero_count", got.size(), 3);
`endif
        rearm();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit         we;
            logic [7:0] v;
            bit         cd;
            we = ($urandom % 2) == 0;
            v  = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
            cd = done_m ? ($urandom % 4 == 0) : ($urandom % 90 == 0);
            cycle(we, v, 8'($urandom), 8'($urandom),
                  ($urandom % 30) == 0, ($urandom % 3) != 0, cd);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/halo_link.md
HALO_LINK -- requirements
Module: halo_link

Interface
- REQ-001: Parameter TILE_SIZE, default 256, tile edge length; coordinate width CW = $clog2(TILE_SIZE).
- REQ-002: Parameter FIFO_DEPTH, default 8, power of two >= 2; entries buffered between source and destination PPU.
- REQ-003: clk  input  1  single clock, all state on rising edge.
- REQ-004: reset  input  1  asynchronous, active-high.
- REQ-005: src_value  input  8  halo partial sum from source PPU neighbor_output_value.
- REQ-006: src_row / src_column  input  CW each  destination-tile coordinates of src_value.
- REQ-007: src_write_enable  input  1  src_* valid this cycle.
- REQ-008: src_exchange_done  input  1  source has issued its last halo entry for this cycle.
- REQ-009: src_cts  output  1  clear-to-send back to source.
- REQ-010: dst_cts  input  1  destination PPU ready to accept one entry.
- REQ-011: dst_value / dst_row / dst_column  output  8 / CW / CW  entry to destination neighbor_input_*.
- REQ-012: dst_write_enable  output  1  dst_* valid, one-cycle pulse per entry.
- REQ-013: dst_exchange_done  output  1  all halo entries delivered (level).
- REQ-014: cycle_done  input  1  global end of PPU cycle, re-arms the link.
- REQ-015: protocol_error  output  1  sticky: push rejected (full, or after done).

Function
- REQ-016: Circular FIFO, FIFO_DEPTH entries of {value, row, column}; $clog2(FIFO_DEPTH)+1-bit count; pointers wrap modulo FIFO_DEPTH.
- REQ-017: src_cts = (count < FIFO_DEPTH) and state in {IDLE, STREAM}; combinational.
- REQ-018: Push accepted when src_write_enable and src_cts; full check uses current count, so push at full is rejected even if a pop occurs in the same cycle.
- REQ-019: Rejected push (full, or state DRAIN/DONE) sets protocol_error; entry is discarded.
- REQ-020: Pop when dst_cts and count > 0; popped entry is registered onto dst_* with dst_write_enable = 1 next cycle; otherwise dst_write_enable = 0 and dst_* hold.
- REQ-021: Latency: entry pushed in cycle N appears on dst_* no earlier than cycle N+1 (empty FIFO, dst_cts high); throughput one entry/cycle.
- REQ-022: Simultaneous push and pop with 0 < count < FIFO_DEPTH: count unchanged, both occur.
- REQ-023: States IDLE, STREAM, DRAIN, DONE.
- REQ-024: IDLE -> STREAM on first accepted push; IDLE -> DRAIN on src_exchange_done (same-cycle push still accepted).
- REQ-025: STREAM -> DRAIN on src_exchange_done; push in that same cycle is accepted.
- REQ-026: DRAIN -> DONE when count = 0 and no pop in flight (dst_write_enable low).
- REQ-027: dst_exchange_done = 1 exactly in DONE.
- REQ-028: DONE -> IDLE on cycle_done; cycle_done in any other state forces IDLE and flushes FIFO (pointers, count to 0).
- REQ-029: protocol_error cleared only by reset or by cycle_done.

Reset
- REQ-030: reset asserted: state IDLE, pointers and count 0, dst_value/dst_row/dst_column 0, dst_write_enable 0, dst_exchange_done 0, protocol_error 0; src_cts therefore 1.
- REQ-031: reset mid-transfer discards FIFO contents with no dst_write_enable pulse; FIFO storage array need not be reset.

Configuration
- REQ-032: Macro HALO_LINK_ZERO_DROP_EN defined: push with src_value = 0 is accepted for handshake purposes but not stored, does not change count, and does not set protocol_error; IDLE -> STREAM still occurs.
- REQ-033: Macro undefined: zero values are stored and forwarded like any other entry.

Verification
- REQ-034: Single push (value 8'h5A, row 3, col 7), dst_cts=1 -> dst_write_enable pulse next cycle with 5A/3/7; then src_exchange_done -> dst_exchange_done high within 2 cycles.
- REQ-035: dst_cts=0, 8 pushes -> src_cts low after 8th; 9th push -> protocol_error=1, count stays 8; dst_cts=1 -> 8 entries out in order, one per cycle.
- REQ-036: Full FIFO, dst_cts=1 and push same cycle -> push rejected, protocol_error=1; count=7 next cycle.
- REQ-037: src_exchange_done with 3 entries queued, dst_cts toggling 1/0 -> DONE only after third dst_write_enable; cycle_done -> dst_exchange_done=0, src_cts=1, protocol_error=0.
- REQ-038: reset asserted with 5 entries queued -> all outputs at reset values same cycle, no further dst_write_enable after release.
- REQ-039: HALO_LINK_ZERO_DROP_EN defined, pushes 0, 9, 0 -> only value 9 delivered; undefined -> 0, 9, 0 delivered.
